neuron_serijski_mac: RTL

//  Parametrised, time-multiplexed neuron for the mine/rock classifier: one mnozenje multiplier

---
 rtl/neuron_pkg.sv | 20 ++
 rtl/Sigmoid_LUT.sv | 27 ++
 rtl/mnozenje.sv | 19 +
 rtl/neuron_tezine_rf.sv | 35 +++
 rtl/neuron_serijski_mac.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared constants and FSM encoding for the serial MAC neuron
//
// Purpose : default widths, sign-bit position and FSM state type used by
//           neuron_serijski_mac and its helpers.
// Ports   : none (package).
package neuron_pkg;

   localparam int W_DEF      = 16;
   localparam int SUMA_W_DEF = 22;
   // Sign-magnitude weights: the top bit of a W_DEF-wide word is the sign.
   localparam int SIGN_BIT   = W_DEF - 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_MAC     = 2'd1,
      S_RAZLIKA = 2'd2,
      S_IZLAZ   = 2'd3
   } stanje_t;

endpackage

// File: rtl/Sigmoid_LUT.sv
// rtl/Sigmoid_LUT.sv - hard-sigmoid approximation of the neuron activation
//
// Purpose : maps a sign-magnitude sum to a W-bit probability centred at
//           2^(W-1): out = half +/- min(suma >> 6, half-1).
// Ports   : suma [SUMA_W-1:0] in, predznak in (1 = negative),
//           verovatnoca [W-1:0] out (combinational).
module Sigmoid_LUT #(
   parameter int SUMA_W = 22,
   parameter int W      = 16
) (
   input  logic [SUMA_W-1:0] suma,
   input  logic              predznak,
   output logic [W-1:0]      verovatnoca
);

   localparam logic [W-1:0] POLA = W'(1) << (W - 1);
   localparam logic [W-1:0] MAXT = POLA - W'(1);

   logic [SUMA_W-1:0] skal;
   logic [W-1:0]      t;

   assign skal = suma >> 6;
   // Clip so that the result stays within 1 .. 2^W-1 for either sign.
   assign t    = (skal > SUMA_W'(MAXT)) ? MAXT : W'(skal);
   assign verovatnoca = predznak ? (POLA - t) : (POLA + t);

endmodule

// File: rtl/mnozenje.sv
// rtl/mnozenje.sv - unsigned fractional multiplier shared by the neuron
//
// Purpose : p = (a * b) >> (W-1). a carries a W-1 bit magnitude (msb 0),
//           b is an unsigned W-bit sample, so the result always fits in W bits.
// Ports   : a [W-1:0] in, b [W-1:0] in, p [W-1:0] out (combinational).
module mnozenje #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] p
);

   logic [2*W-1:0] pun;

   assign pun = a * b;
   assign p   = W'(pun >> (W - 1));

endmodule

// File: rtl/neuron_tezine_rf.sv
// rtl/neuron_tezine_rf.sv - weight register file for the serial MAC neuron
//
// Purpose : N_ULAZA x W storage, synchronous write, asynchronous read,
//           synchronous clear on rst. Out-of-range write addresses are ignored.
// Ports   : clk, rst, we, wr_adr [ADR_W-1:0], wr_data [W-1:0],
//           rd_adr [ADR_W-1:0] in; rd_data [W-1:0] out.
module neuron_tezine_rf #(
   parameter int N_ULAZA = 60,
   parameter int W       = 16,
   parameter int ADR_W   = $clog2(N_ULAZA)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [ADR_W-1:0] wr_adr,
   input  logic [W-1:0]     wr_data,
   input  logic [ADR_W-1:0] rd_adr,
   output logic [W-1:0]     rd_data
);

   logic [W-1:0] mem [N_ULAZA];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_ULAZA; i++) begin
            mem[i] <= '0;
         end
      end else if (we && (int'(wr_adr) < N_ULAZA)) begin
         mem[wr_adr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_adr];

endmodule

// File: rtl/neuron_serijski_mac.sv
// rtl/neuron_serijski_mac.sv - time-multiplexed neuron, one product per clock
//
// Purpose : latches an N_ULAZA-sample vector, multiplies each sample by its
//           sign-magnitude weight through a single shared multiplier, keeps
//           saturating positive/negative sums, forms |P-N| and its sign and
//           drives the result through the sigmoid.
// Ports   : clk, rst (sync, active high); tezina_we/tezina_adr/tezina_data
//           weight write port (IDLE only); pokreni start (IDLE only);
//           uzorak input vector; zauzet busy; gotovo one-cycle done pulse;
//           izlaz probability; generalna_suma |P-N|; predznak 1 = negative.
module neuron_serijski_mac
   import neuron_pkg::*;
#(
   parameter int N_ULAZA = 60,
   parameter int W       = W_DEF,
   parameter int SUMA_W  = SUMA_W_DEF,
   parameter int ADR_W   = $clog2(N_ULAZA)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tezina_we,
   input  logic [ADR_W-1:0]     tezina_adr,
   input  logic [W-1:0]         tezina_data,
   input  logic                 pokreni,
   input  logic [N_ULAZA*W-1:0] uzorak,
   output logic                 zauzet,
   output logic                 gotovo,
   output logic [W-1:0]         izlaz,
   output logic [SUMA_W-1:0]    generalna_suma,
   output logic                 predznak
);

   // Sign bit follows W when the block is built wider or narrower than default.
   localparam int               ZNAK = SIGN_BIT + (W - W_DEF);
   localparam logic [ADR_W-1:0] POSL = ADR_W'(N_ULAZA - 1);

   stanje_t                stanje;
   logic [ADR_W-1:0]       indeks;
   logic [N_ULAZA*W-1:0]   uzorak_reg;
   logic [SUMA_W-1:0]      suma_p;
   logic [SUMA_W-1:0]      suma_n;

   logic [W-1:0]           tezina;
   logic [W-1:0]           proizvod;
   logic [W-1:0]           sig_val;
   logic [SUMA_W:0]        p_zbir;
   logic [SUMA_W:0]        n_zbir;
   logic [SUMA_W-1:0]      p_sat;
   logic [SUMA_W-1:0]      n_sat;

   neuron_tezine_rf #(
      .N_ULAZA (N_ULAZA),
      .W       (W),
      .ADR_W   (ADR_W)
   ) u_rf (
      .clk     (clk),
      .rst     (rst),
      .we      (tezina_we && (stanje == S_IDLE)),
      .wr_adr  (tezina_adr),
      .wr_data (tezina_data),
      .rd_adr  (indeks),
      .rd_data (tezina)
   );

   // The sample vector is shifted down one element per MAC cycle, so the
   // current sample is always in the low W bits.
   mnozenje #(
      .W (W)
   ) u_mnozenje (
      .a ({1'b0, tezina[ZNAK-1:0]}),
      .b (uzorak_reg[W-1:0]),
      .p (proizvod)
   );

   Sigmoid_LUT #(
      .SUMA_W (SUMA_W),
      .W      (W)
   ) u_sigmoid (
      .suma        (generalna_suma),
      .predznak    (predznak),
      .verovatnoca (sig_val)
   );

   // One extra bit catches the carry; on carry the sum pins at all ones.
   assign p_zbir = {1'b0, suma_p} + (SUMA_W+1)'(proizvod);
   assign n_zbir = {1'b0, suma_n} + (SUMA_W+1)'(proizvod);
   assign p_sat  = p_zbir[SUMA_W] ? '1 : p_zbir[SUMA_W-1:0];
   assign n_sat  = n_zbir[SUMA_W] ? '1 : n_zbir[SUMA_W-1:0];

   assign zauzet = (stanje != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         stanje         <= S_IDLE;
         indeks         <= '0;
         uzorak_reg     <= '0;
         suma_p         <= '0;
         suma_n         <= '0;
         generalna_suma <= '0;
         predznak       <= 1'b0;
         izlaz          <= '0;
         gotovo         <= 1'b0;
      end else begin
         gotovo <= 1'b0;
         case (stanje)
            S_IDLE: begin
               if (pokreni) begin
                  uzorak_reg <= uzorak;
                  suma_p     <= '0;
                  suma_n     <= '0;
                  indeks     <= '0;
                  stanje     <= S_MAC;
               end
            end
            S_MAC: begin
               // Negative zero adds a zero product, so it needs no special case.
               if (tezina[ZNAK]) begin
                  suma_n <= n_sat;
               end else begin
                  suma_p <= p_sat;
               end
               uzorak_reg <= uzorak_reg >> W;
               if (indeks == POSL) begin
                  stanje <= S_RAZLIKA;
               end else begin
                  indeks <= indeks + ADR_W'(1);
               end
            end
            S_RAZLIKA: begin
               // A tie is reported as zero magnitude with the negative sign.
               if (suma_p > suma_n) begin
                  generalna_suma <= suma_p - suma_n;
                  predznak       <= 1'b0;
               end else begin
                  generalna_suma <= suma_n - suma_p;
                  predznak       <= 1'b1;
               end
               stanje <= S_IZLAZ;
            end
            S_IZLAZ: begin
               izlaz  <= sig_val;
               gotovo <= 1'b1;
               stanje <= S_IDLE;
            end
            default: stanje <= S_IDLE;
         endcase
      end
   end

endmodule
